// File: rtl/idex_elastic_stage_pkg.sv
// Shared constants for the ID->EX elastic stage: side-band width and the field offsets
// of the side-band above the lane payload in each storage word.
package idex_elastic_stage_pkg;

  localparam int IDEX_SIDE_W  = 34;
  localparam int IDEX_DS_OFF  = 0;
  localparam int IDEX_EXC_OFF = 1;
  localparam int IDEX_PC_OFF  = 2;

endpackage

// File: rtl/idex_ptr_ctr.sv
// Wrap-around queue pointer: increments modulo 2**PTR_W, synchronous clear wins over inc.
module idex_ptr_ctr #(
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/idex_elastic_stage.sv
// ID->EX elastic queue: DEPTH entries of LANES decoded lanes plus pc/exc/delay-slot side-band.
// Optional IDEX_PERF_CNT_EN adds saturating stall and bubble counters.
module idex_elastic_stage
  import idex_elastic_stage_pkg::*;
#(
  parameter  int LANE_W = 32,
  parameter  int LANES  = 1,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_payload,
  input  logic [31:0]             in_pc,
  input  logic                    in_exc,
  input  logic                    in_delay_slot,
  input  logic                    nullify,
  input  logic                    irq_kill,
  input  logic                    flush,
  input  logic                    kill_head,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_payload,
  output logic [31:0]             out_pc,
  output logic                    out_exc,
  output logic                    out_delay_slot,
  output logic [PTR_W:0]          occupancy
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall,
  output logic [31:0]             perf_bubble
`endif
);

  localparam int PAY_W  = LANES * LANE_W;
  localparam int WORD_W = PAY_W + IDEX_SIDE_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] in_word, head_word, hold_word, out_word;
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;
  logic              nonempty, enq, deq, head_adv;

  assign nonempty  = (count != '0);
  assign in_ready  = (count != FULL_CNT);
  assign enq       = in_valid & in_ready & ~nullify & ~irq_kill & ~flush;
  assign out_valid = nonempty & ~flush & ~kill_head;
  assign deq       = out_valid & out_ready;
  assign head_adv  = deq | (kill_head & ~flush & nonempty);
  assign occupancy = count;

  idex_ptr_ctr #(.PTR_W(PTR_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (head_adv),
    .ptr   (head)
  );

  idex_ptr_ctr #(.PTR_W(PTR_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (enq),
    .ptr   (tail)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(head_adv);
    end
  end

  always_comb begin
    in_word                           = '0;
    in_word[PAY_W-1:0]                = in_payload;
    in_word[PAY_W+IDEX_DS_OFF]        = in_delay_slot;
    in_word[PAY_W+IDEX_EXC_OFF]       = in_exc;
    in_word[PAY_W+IDEX_PC_OFF +: 32]  = in_pc;
  end

  // ---- enqueue boundary: storage is data only, no reset ----
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= in_word;
    end
  end

  assign head_word = mem[head];

  // The slot behind a departing head is stale, so an empty queue shows the last departed entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_word <= '0;
    end else if (head_adv) begin
      hold_word <= head_word;
    end
  end

  assign out_word       = nonempty ? head_word : hold_word;
  assign out_payload    = out_word[PAY_W-1:0];
  assign out_delay_slot = out_word[PAY_W+IDEX_DS_OFF];
  assign out_exc        = out_word[PAY_W+IDEX_EXC_OFF];
  assign out_pc         = out_word[PAY_W+IDEX_PC_OFF +: 32];

`ifdef IDEX_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
    end else begin
      if (in_valid & ~in_ready) perf_stall <= sat_inc(perf_stall);
      if (~out_valid & out_ready) perf_bubble <= sat_inc(perf_bubble);
    end
  end
`endif

endmodule

// File: tb/tb_idex_elastic_stage.sv
// Scoreboard bench for idex_elastic_stage: expected entries queued at issue, popped by a monitor.
module tb_idex_elastic_stage;

  localparam int LANE_W = 32;
  localparam int LANES  = 1;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_payload;
  logic [31:0]       in_pc;
  logic              in_exc;
  logic              in_delay_slot;
  logic              nullify;
  logic              irq_kill;
  logic              flush;
  logic              kill_head;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_payload;
  logic [31:0]       out_pc;
  logic              out_exc;
  logic              out_delay_slot;
  logic [PTR_W:0]    occupancy;

  idex_elastic_stage #(.LANE_W(LANE_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_payload     (in_payload),
    .in_pc          (in_pc),
    .in_exc         (in_exc),
    .in_delay_slot  (in_delay_slot),
    .nullify        (nullify),
    .irq_kill       (irq_kill),
    .flush          (flush),
    .kill_head      (kill_head),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_payload    (out_payload),
    .out_pc         (out_pc),
    .out_exc        (out_exc),
    .out_delay_slot (out_delay_slot),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] payload;
    logic        exc;
    logic        ds;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] pay, input logic exc,
                      input logic ds, input bit expect_out);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_payload    = pay;
    in_exc        = exc;
    in_delay_slot = ds;
    if (expect_out) sb.push_back('{pc, pay, exc, ds});
    tick();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %0h, required no output", out_pc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_payload", out_payload, e.payload);
        chk("out_exc", out_exc, e.exc);
        chk("out_delay_slot", out_delay_slot, e.ds);
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_payload = '0; in_pc = '0; in_exc = 1'b0;
    in_delay_slot = 1'b0; nullify = 1'b0; irq_kill = 1'b0; flush = 1'b0;
    kill_head = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    reset = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_payload", out_payload, 0);

    // single entry, one-cycle latency
    send(32'h3000, 32'hA5, 1'b0, 1'b0, 1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_pc", out_pc, 32'h3000);
    chk("t1_out_payload", out_payload, 32'hA5);
    chk("t1_occupancy", occupancy, 1);

    // fill to full, extra entry refused, then drain in order
    send(32'h3004, 32'hB6, 1'b1, 1'b0, 1);
    send(32'h3008, 32'hC7, 1'b0, 1'b1, 1);
    send(32'h300C, 32'hD8, 1'b0, 1'b0, 1);
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_occupancy_full", occupancy, DEPTH);
    in_valid = 1'b1; in_pc = 32'h3010; in_payload = 32'hE9;
    tick();
    tick();
    in_valid = 1'b0;
    chk("t2_occupancy_held", occupancy, DEPTH);
    chk("t2_head_pc", out_pc, 32'h3000);
    out_ready = 1'b1;
    repeat (DEPTH) tick();
    chk("t2_drained", occupancy, 0);
    chk("t2_out_valid_empty", out_valid, 0);
    chk("t2_hold_pc", out_pc, 32'h300C);
    out_ready = 1'b0;

    // flush with a concurrent in_valid
    send(32'h4000, 32'h11, 1'b0, 1'b0, 0);
    send(32'h4004, 32'h22, 1'b0, 1'b0, 0);
    chk("t3_occupancy_pre", occupancy, 2);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4008; in_payload = 32'h33;
    #1;
    chk("t3_out_valid_flush", out_valid, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_occupancy_post", occupancy, 0);
    chk("t3_out_valid_post", out_valid, 0);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("t3_occupancy_idle", occupancy, 0);

    // nullify and irq_kill consume without writing
    in_valid = 1'b1; nullify = 1'b1; in_pc = 32'h4100;
    #1;
    chk("t4_in_ready_nullify", in_ready, 1);
    tick();
    chk("t4_occupancy_nullify", occupancy, 0);
    chk("t4_out_valid_nullify", out_valid, 0);
    nullify = 1'b0; irq_kill = 1'b1; in_pc = 32'h4104;
    #1;
    chk("t4_in_ready_irq", in_ready, 1);
    tick();
    irq_kill = 1'b0; in_valid = 1'b0;
    chk("t4_occupancy_irq", occupancy, 0);
    chk("t4_out_valid_irq", out_valid, 0);

    // kill_head together with an enqueue
    out_ready = 1'b0;
    send(32'h5000, 32'hAA, 1'b0, 1'b0, 0);
    send(32'h5004, 32'hBB, 1'b1, 1'b0, 1);
    kill_head = 1'b1; in_valid = 1'b1; in_pc = 32'h5008; in_payload = 32'hCC;
    in_exc = 1'b0; in_delay_slot = 1'b1;
    sb.push_back('{32'h5008, 32'hCC, 1'b0, 1'b1});
    #1;
    chk("t5_out_valid_kill", out_valid, 0);
    tick();
    kill_head = 1'b0; in_valid = 1'b0;
    chk("t5_occupancy", occupancy, 2);
    chk("t5_head_pc", out_pc, 32'h5004);
    chk("t5_head_exc", out_exc, 1);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("t5_drained", occupancy, 0);
    kill_head = 1'b1;
    tick();
    kill_head = 1'b0;
    chk("t5_kill_empty_occ", occupancy, 0);
    chk("t5_kill_empty_ready", in_ready, 1);

    // streaming with wrap-around
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      send(32'h6000 + 32'(4 * i), 32'(i), i[0], i[1], 1);
      chk("t6_occupancy", occupancy, 1);
    end
    tick();
    chk("t6_drained", occupancy, 0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    send(32'h7000, 32'h77, 1'b0, 1'b0, 0);
    chk("t7_occupancy_pre", occupancy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t7_occupancy_rst", occupancy, 0);
    chk("t7_out_valid_rst", out_valid, 0);
    chk("t7_out_pc_rst", out_pc, 0);
    reset = 1'b1;
    tick();
    chk("t7_in_ready", in_ready, 1);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
